// File: rtl/audio_axil_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_axil_pkg
// Description : Shared constants for the audio AXI4-Lite register slave.
// Revision    : 1.0 - initial release
// ============================================================================
package audio_axil_pkg;

    localparam int C_REG_CTRL     = 'h00;
    localparam int C_REG_STATUS   = 'h04;
    localparam int C_REG_SCRATCH  = 'h08;
    localparam int C_REG_IRQ_MASK = 'h0C;
    localparam int C_REG_SAMPLE0  = 'h10;

    localparam logic [1:0] C_RESP_OKAY   = 2'b00;
    localparam logic [1:0] C_RESP_SLVERR = 2'b10;

    localparam int C_CTRL_ENABLE    = 0;
    localparam int C_CTRL_CLR_OVF   = 1;
    localparam int C_STATUS_OVF_LSB = 16;

    // Expand a 4-bit byte strobe into a 32-bit bit mask.
    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/audio_sample_latch.sv
`default_nettype none
// ============================================================================
// Module      : audio_sample_latch
// Description : One capture channel: sample register, new and overflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_sample_latch #(
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_enable,
    input  logic                i_valid,
    input  logic [SAMPLE_W-1:0] i_data,
    input  logic                i_clr_new,
    input  logic                i_clr_ovf,
    output logic [SAMPLE_W-1:0] o_sample,
    output logic                o_new,
    output logic                o_ovf
);

    logic [SAMPLE_W-1:0] r_sample;
    logic                r_new;
    logic                r_ovf;
    logic                w_capture;

    assign w_capture = i_enable & i_valid;

    // A read consuming the pending sample on the capture edge is not an overflow;
    // a capture overflow outranks a simultaneous overflow clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample <= '0;
            r_new    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_capture) begin
                r_sample <= i_data;
            end
            if (w_capture) begin
                r_new <= 1'b1;
            end else if (i_clr_new) begin
                r_new <= 1'b0;
            end
            if (w_capture && r_new && !i_clr_new) begin
                r_ovf <= 1'b1;
            end else if (i_clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign o_sample = r_sample;
    assign o_new    = r_new;
    assign o_ovf    = r_ovf;

endmodule
`default_nettype wire

// File: rtl/audio_axil_regs.sv
`default_nettype none
// ============================================================================
// Module      : audio_axil_regs
// Description : AXI4-Lite register slave with per-channel audio sample capture.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_axil_regs
    import audio_axil_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int SAMPLE_W = 16,
    parameter int ADDR_W   = 8
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic [ADDR_W-1:0]          S_AXI_AWADDR,
    input  logic                       S_AXI_AWVALID,
    output logic                       S_AXI_AWREADY,
    input  logic [31:0]                S_AXI_WDATA,
    input  logic [3:0]                 S_AXI_WSTRB,
    input  logic                       S_AXI_WVALID,
    output logic                       S_AXI_WREADY,
    output logic [1:0]                 S_AXI_BRESP,
    output logic                       S_AXI_BVALID,
    input  logic                       S_AXI_BREADY,
    input  logic [ADDR_W-1:0]          S_AXI_ARADDR,
    input  logic                       S_AXI_ARVALID,
    output logic                       S_AXI_ARREADY,
    output logic [31:0]                S_AXI_RDATA,
    output logic [1:0]                 S_AXI_RRESP,
    output logic                       S_AXI_RVALID,
    input  logic                       S_AXI_RREADY,
    input  logic [NUM_CH-1:0]          smp_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0] smp_data,
    output logic                       ctrl_enable,
    output logic                       irq
);

    localparam int C_AW = ADDR_W - 2;
    localparam logic [C_AW-1:0] C_WORD_CTRL     = C_AW'(C_REG_CTRL / 4);
    localparam logic [C_AW-1:0] C_WORD_STATUS   = C_AW'(C_REG_STATUS / 4);
    localparam logic [C_AW-1:0] C_WORD_SCRATCH  = C_AW'(C_REG_SCRATCH / 4);
    localparam logic [C_AW-1:0] C_WORD_IRQ_MASK = C_AW'(C_REG_IRQ_MASK / 4);

    logic               r_aw_held, r_w_held, r_bvalid, r_rvalid;
    logic [C_AW-1:0]    r_aw_word;
    logic [31:0]        r_wdata, r_rdata, r_scratch;
    logic [3:0]         r_wstrb;
    logic [1:0]         r_bresp, r_rresp;
    logic               r_enable, r_irq;
    logic [NUM_CH-1:0]  r_irq_mask;

    logic               w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic [C_AW-1:0]    w_ar_word;
    logic               w_wr_ctrl, w_wr_scratch, w_wr_mask, w_wr_ok, w_clr_ovf;
    logic [31:0]        w_bitmask, w_rd_data;
    logic               w_rd_ok;
    logic [NUM_CH-1:0]  w_new, w_ovf, w_clr_new;
    logic [SAMPLE_W-1:0] w_sample [NUM_CH];
    logic               w_unused_addr_lsbs;

    assign w_unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_AWREADY = !r_aw_held && !r_bvalid;
    assign S_AXI_WREADY  = !r_w_held && !r_bvalid;
    assign S_AXI_ARREADY = !r_rvalid;

    assign w_aw_hs   = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_w_hs    = S_AXI_WVALID & S_AXI_WREADY;
    assign w_ar_hs   = S_AXI_ARVALID & S_AXI_ARREADY;
    assign w_commit  = r_aw_held & r_w_held;
    assign w_ar_word = S_AXI_ARADDR[ADDR_W-1:2];
    assign w_bitmask = strb_to_mask(r_wstrb);

    always_comb begin
        w_wr_ctrl    = 1'b0;
        w_wr_scratch = 1'b0;
        w_wr_mask    = 1'b0;
        case (r_aw_word)
            C_WORD_CTRL:     w_wr_ctrl    = 1'b1;
            C_WORD_SCRATCH:  w_wr_scratch = 1'b1;
            C_WORD_IRQ_MASK: w_wr_mask    = 1'b1;
            default:         ;
        endcase
        w_wr_ok = w_wr_ctrl | w_wr_scratch | w_wr_mask;
    end

    assign w_clr_ovf = w_commit & w_wr_ctrl & r_wstrb[0] & r_wdata[C_CTRL_CLR_OVF];

    always_comb begin
        w_rd_data = '0;
        w_rd_ok   = 1'b1;
        case (w_ar_word)
            C_WORD_CTRL:     w_rd_data[C_CTRL_ENABLE] = r_enable;
            C_WORD_STATUS: begin
                w_rd_data[NUM_CH-1:0]                 = w_new;
                w_rd_data[C_STATUS_OVF_LSB +: NUM_CH] = w_ovf;
            end
            C_WORD_SCRATCH:  w_rd_data = r_scratch;
            C_WORD_IRQ_MASK: w_rd_data[NUM_CH-1:0] = r_irq_mask;
            default: begin
                w_rd_ok = 1'b0;
                for (int k = 0; k < NUM_CH; k++) begin
                    if (w_ar_word == C_AW'(C_REG_SAMPLE0 / 4 + k)) begin
                        w_rd_data = 32'(w_sample[k]);
                        w_rd_ok   = 1'b1;
                    end
                end
            end
        endcase
    end

    // Write path: address and data are parked independently, committed together.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_aw_held  <= 1'b0;
            r_aw_word  <= '0;
            r_w_held   <= 1'b0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= C_RESP_OKAY;
            r_enable   <= 1'b0;
            r_scratch  <= '0;
            r_irq_mask <= '0;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_word <= S_AXI_AWADDR[ADDR_W-1:2];
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= S_AXI_WDATA;
                r_wstrb  <= S_AXI_WSTRB;
            end
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_ok ? C_RESP_OKAY : C_RESP_SLVERR;
                if (w_wr_ctrl && r_wstrb[0]) begin
                    r_enable <= r_wdata[C_CTRL_ENABLE];
                end
                if (w_wr_scratch) begin
                    r_scratch <= (r_scratch & ~w_bitmask) | (r_wdata & w_bitmask);
                end
                if (w_wr_mask) begin
                    r_irq_mask <= (r_irq_mask & ~w_bitmask[NUM_CH-1:0])
                                | (r_wdata[NUM_CH-1:0] & w_bitmask[NUM_CH-1:0]);
                end
            end else if (r_bvalid && S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= C_RESP_OKAY;
            r_irq    <= 1'b0;
        end else begin
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
                r_rresp  <= w_rd_ok ? C_RESP_OKAY : C_RESP_SLVERR;
            end else if (r_rvalid && S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end
            r_irq <= |(w_new & r_irq_mask);
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign w_clr_new[k] = w_ar_hs && (w_ar_word == C_AW'(C_REG_SAMPLE0 / 4 + k));

        audio_sample_latch #(
            .SAMPLE_W (SAMPLE_W)
        ) u_latch (
            .clk       (ACLK),
            .rst       (ARESET),
            .i_enable  (r_enable),
            .i_valid   (smp_valid[k]),
            .i_data    (smp_data[k*SAMPLE_W +: SAMPLE_W]),
            .i_clr_new (w_clr_new[k]),
            .i_clr_ovf (w_clr_ovf),
            .o_sample  (w_sample[k]),
            .o_new     (w_new[k]),
            .o_ovf     (w_ovf[k])
        );
    end

    assign S_AXI_BVALID = r_bvalid;
    assign S_AXI_BRESP  = r_bresp;
    assign S_AXI_RVALID = r_rvalid;
    assign S_AXI_RDATA  = r_rdata;
    assign S_AXI_RRESP  = r_rresp;
    assign ctrl_enable  = r_enable;
    assign irq          = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_audio_axil_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_axil_regs
// Description : Self-checking bench for audio_axil_regs (vectors, corners, random).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_axil_regs;

    localparam int NUM_CH   = 4;
    localparam int SAMPLE_W = 16;
    localparam int ADDR_W   = 8;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic clk = 1'b0;
    logic rst;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic awvalid, awready, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [NUM_CH-1:0] smp_valid;
    logic [NUM_CH*SAMPLE_W-1:0] smp_data;
    logic ctrl_enable, irq;

    int n_checks = 0;
    int n_errors = 0;
    int b_count  = 0;
    logic [31:0] last_rdata;

    // Reference model state
    logic [SAMPLE_W-1:0] m_sample [NUM_CH];
    logic [NUM_CH-1:0]   m_new, m_ovf, m_mask;
    logic                m_enable;
    logic [31:0]         m_scratch;

    typedef struct {
        bit          is_wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    always @(posedge clk) if (bvalid && bready) b_count <= b_count + 1;

    audio_axil_regs #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .ADDR_W(ADDR_W)) dut (
        .ACLK(clk), .ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .smp_valid(smp_valid), .smp_data(smp_data),
        .ctrl_enable(ctrl_enable), .irq(irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic m_reset();
        for (int k = 0; k < NUM_CH; k++) m_sample[k] = '0;
        m_new = '0; m_ovf = '0; m_mask = '0; m_enable = 1'b0; m_scratch = '0;
    endtask

    task automatic m_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] r);
        int w;
        w = int'(a) / 4;
        r = OKAY;
        if (w == 0) begin
            if (s[0]) begin
                m_enable = d[0];
                if (d[1]) m_ovf = '0;
            end
        end else if (w == 2 || w == 3) begin
            logic [31:0] v;
            v = (w == 2) ? m_scratch : 32'(m_mask);
            for (int b = 0; b < 4; b++) if (s[b]) v[b*8 +: 8] = d[b*8 +: 8];
            if (w == 2) m_scratch = v; else m_mask = v[NUM_CH-1:0];
        end else begin
            r = SLVERR;
        end
    endtask

    task automatic m_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
        int w;
        w = int'(a) / 4;
        d = '0;
        r = OKAY;
        if (w == 0) d[0] = m_enable;
        else if (w == 1) begin
            d[NUM_CH-1:0] = m_new;
            d[16 +: NUM_CH] = m_ovf;
        end
        else if (w == 2) d = m_scratch;
        else if (w == 3) d[NUM_CH-1:0] = m_mask;
        else if (w >= 4 && w < 4 + NUM_CH) begin
            d[SAMPLE_W-1:0] = m_sample[w-4];
            m_new[w-4] = 1'b0;
        end else r = SLVERR;
    endtask

    task automatic m_capture(input logic [NUM_CH-1:0] msk, input logic [NUM_CH*SAMPLE_W-1:0] d);
        if (m_enable) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (msk[k]) begin
                    if (m_new[k]) m_ovf[k] = 1'b1;
                    m_new[k] = 1'b1;
                    m_sample[k] = d[k*SAMPLE_W +: SAMPLE_W];
                end
            end
        end
    endtask

    // ---------------- bus drivers ----------------
    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] r);
        bit aw_done, w_done, aw_hs, w_hs;
        int n;
        @(posedge clk); #1;
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
        aw_done = 0; w_done = 0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_hs) begin aw_done = 1; awvalid = 1'b0; end
            if (w_hs)  begin w_done = 1;  wvalid  = 1'b0; end
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
        r = bresp;
        if (!bvalid) begin
            n_checks++; n_errors++;
            $display("FAIL wr_timeout: got bvalid=0 expected bvalid=1 addr=%h", a);
            r = 2'bxx;
        end
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
        int n;
        @(posedge clk); #1;
        araddr = a; arvalid = 1'b1; rready = 1'b0;
        n = 0;
        while (!arready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("rd_latency", 32'(rvalid), 32'd1);
        d = rdata; r = rresp;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic rd_model(input string name, input logic [7:0] a);
        logic [31:0] ed, d;
        logic [1:0]  er, r;
        m_read(a, ed, er);
        axi_read(a, d, r);
        last_rdata = d;
        check(name, d, ed);
        check({name, "_resp"}, 32'(r), 32'(er));
    endtask

    task automatic wr_model(input string name, input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        logic [1:0] er, r;
        m_write(a, d, s, er);
        axi_write(a, d, s, r);
        check(name, 32'(r), 32'(er));
    endtask

    task automatic pulse(input logic [NUM_CH-1:0] msk, input logic [NUM_CH*SAMPLE_W-1:0] d);
        @(posedge clk); #1;
        smp_valid = msk; smp_data = d;
        @(posedge clk); #1;
        smp_valid = '0;
        m_capture(msk, d);
    endtask

    function automatic vec_t mk(bit w, logic [7:0] a, logic [31:0] d, logic [3:0] s,
                                logic [31:0] ed, logic [1:0] er);
        vec_t v;
        v.is_wr = w; v.addr = a; v.data = d; v.strb = s; v.exp_data = ed; v.exp_resp = er;
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r, er;
        logic [NUM_CH*SAMPLE_W-1:0] sd;
        int b0;

        vecs.push_back(mk(0, 8'h00, 0, 0, 32'h0, OKAY));
        vecs.push_back(mk(0, 8'h04, 0, 0, 32'h0, OKAY));
        vecs.push_back(mk(0, 8'h08, 0, 0, 32'h0, OKAY));
        vecs.push_back(mk(0, 8'h0C, 0, 0, 32'h0, OKAY));
        vecs.push_back(mk(1, 8'h08, 32'hDEADBEEF, 4'b0101, 0, OKAY));
        vecs.push_back(mk(0, 8'h08, 0, 0, 32'h00AD00EF, OKAY));
        vecs.push_back(mk(1, 8'h04, 32'hFFFFFFFF, 4'hF, 0, SLVERR));
        vecs.push_back(mk(0, 8'h40, 0, 0, 32'h0, SLVERR));
        vecs.push_back(mk(0, 8'h04, 0, 0, 32'h0, OKAY));
        vecs.push_back(mk(0, 8'h0A, 0, 0, 32'h00AD00EF, OKAY));
        vecs.push_back(mk(1, 8'h0C, 32'hFFFFFFFF, 4'hF, 0, OKAY));
        vecs.push_back(mk(0, 8'h0C, 0, 0, 32'h0000000F, OKAY));
        vecs.push_back(mk(1, 8'h0C, 32'h00000002, 4'h1, 0, OKAY));
        vecs.push_back(mk(0, 8'h0C, 0, 0, 32'h00000002, OKAY));
        vecs.push_back(mk(1, 8'h00, 32'h00000003, 4'h1, 0, OKAY));
        vecs.push_back(mk(0, 8'h00, 0, 0, 32'h00000001, OKAY));
        vecs.push_back(mk(1, 8'h00, 32'hFFFFFFFE, 4'b1110, 0, OKAY));
        vecs.push_back(mk(0, 8'h00, 0, 0, 32'h00000001, OKAY));

        rst = 1'b1;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0; smp_valid = '0; smp_data = '0;
        m_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_ready", {29'd0, awready, wready, arready}, 32'd7);
        check("rst_valid", {30'd0, bvalid, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_misc", {26'd0, bresp, rresp, irq, ctrl_enable}, 32'd0);

        foreach (vecs[i]) begin
            if (vecs[i].is_wr) begin
                m_write(vecs[i].addr, vecs[i].data, vecs[i].strb, er);
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
                check($sformatf("vec%0d_bresp", i), 32'(r), 32'(vecs[i].exp_resp));
            end else begin
                m_read(vecs[i].addr, d, er);
                axi_read(vecs[i].addr, d, r);
                check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_data);
                check($sformatf("vec%0d_rresp", i), 32'(r), 32'(vecs[i].exp_resp));
            end
        end

        // W leads AW by 3 cycles, BREADY held low 5 cycles
        b0 = b_count;
        @(posedge clk); #1;
        wdata = 32'h11223344; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
        @(posedge clk); #1;
        wvalid = 1'b0;
        check("wfirst_wready_low", 32'(wready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("wfirst_awready", 32'(awready), 32'd1);
        awaddr = 8'h08; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        @(posedge clk); #1;
        check("wfirst_bvalid", 32'(bvalid), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("wfirst_bvalid_held", 32'(bvalid), 32'd1);
        check("wfirst_no_early_b", 32'(b_count - b0), 32'd0);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check("wfirst_bvalid_drop", 32'(bvalid), 32'd0);
        check("wfirst_single_b", 32'(b_count - b0), 32'd1);
        m_write(8'h08, 32'h11223344, 4'hF, er);
        rd_model("wfirst_readback", 8'h08);

        // ch2 capture and clear-on-read
        sd = '0; sd[2*SAMPLE_W +: SAMPLE_W] = 16'h1234;
        pulse(4'b0100, sd);
        rd_model("ch2_status", 8'h04);
        check("ch2_new_set", 32'(last_rdata[2]), 32'd1);
        rd_model("ch2_sample", 8'h18);
        check("ch2_value", last_rdata, 32'h00001234);
        rd_model("ch2_status_after", 8'h04);
        check("ch2_new_clr", 32'(last_rdata[2]), 32'd0);

        // overflow and clr_ovf
        sd = '0; sd[15:0] = 16'h0A0A; pulse(4'b0001, sd);
        sd[15:0] = 16'h0B0B;          pulse(4'b0001, sd);
        rd_model("ovf_status", 8'h04);
        check("ovf_set", 32'(last_rdata[16]), 32'd1);
        wr_model("clr_ovf_wr", 8'h00, 32'h3, 4'h1);
        rd_model("ovf_status_after", 8'h04);
        check("ovf_clr", 32'(last_rdata[16]), 32'd0);
        check("enable_kept", 32'(ctrl_enable), 32'd1);

        // irq masking (mask = 0x2)
        rd_model("irq_prep", 8'h10);
        sd = '0; sd[15:0] = 16'h0101; pulse(4'b0001, sd);
        repeat (2) @(posedge clk);
        #1;
        check("irq_masked_ch0", 32'(irq), 32'd0);
        sd = '0; sd[SAMPLE_W +: SAMPLE_W] = 16'h0202;
        pulse(4'b0010, sd);
        check("irq_lag", 32'(irq), 32'd0);
        @(posedge clk); #1;
        check("irq_ch1", 32'(irq), 32'd1);
        rd_model("irq_rd_ch1", 8'h14);
        check("irq_cleared", 32'(irq), 32'd0);

        // read of SAMPLE3 on the same edge as a new ch3 sample
        sd = '0; sd[3*SAMPLE_W +: SAMPLE_W] = 16'hAAAA;
        pulse(4'b1000, sd);
        m_read(8'h1C, d, er);
        sd[3*SAMPLE_W +: SAMPLE_W] = 16'hBBBB;
        @(posedge clk); #1;
        araddr = 8'h1C; arvalid = 1'b1; rready = 1'b0;
        smp_valid = 4'b1000; smp_data = sd;
        @(posedge clk); #1;
        arvalid = 1'b0; smp_valid = '0;
        m_capture(4'b1000, sd);
        check("coll_rd_old", rdata, d);
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        rd_model("coll_status", 8'h04);
        check("coll_new_kept", 32'(last_rdata[3]), 32'd1);
        check("coll_no_ovf", 32'(last_rdata[19]), 32'd0);
        rd_model("coll_new_value", 8'h1C);

        // clr_ovf commit on the same edge as an overflowing ch0 sample
        @(posedge clk); #1;
        awaddr = 8'h00; awvalid = 1'b1; wdata = 32'h3; wstrb = 4'h1; wvalid = 1'b1; bready = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        sd = '0; sd[15:0] = 16'h5555;
        smp_valid = 4'b0001; smp_data = sd;
        @(posedge clk); #1;
        smp_valid = '0;
        check("coll_clr_bvalid", 32'(bvalid), 32'd1);
        @(posedge clk); #1;
        bready = 1'b0;
        m_write(8'h00, 32'h3, 4'h1, er);
        m_capture(4'b0001, sd);
        rd_model("coll_clr_status", 8'h04);
        check("coll_ovf_wins", 32'(last_rdata[16]), 32'd1);

        // reset with a read response and a write in flight
        @(posedge clk); #1;
        araddr = 8'h08; arvalid = 1'b1; rready = 1'b0;
        awaddr = 8'h08; awvalid = 1'b1; wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mrst_valids", {30'd0, bvalid, rvalid}, 32'd0);
        check("mrst_outs", {29'd0, awready, irq, ctrl_enable}, 32'd4);
        m_reset();
        rd_model("mrst_scratch", 8'h08);
        rd_model("mrst_status", 8'h04);

        // randomized traffic against the model
        wr_model("rnd_enable", 8'h00, 32'h1, 4'h1);
        for (int it = 0; it < 200; it++) begin
            int op;
            logic [7:0] a;
            op = $urandom_range(0, 2);
            a = 8'($urandom_range(0, 23) * 4 + $urandom_range(0, 3));
            if (op == 0) begin
                wr_model("rnd_bresp", a, $urandom, 4'($urandom_range(0, 15)));
            end else if (op == 1) begin
                rd_model("rnd_rdata", a);
            end else begin
                for (int k = 0; k < NUM_CH; k++) sd[k*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'($urandom);
                pulse(4'($urandom_range(0, 15)), sd);
                @(posedge clk); #1;
            end
            check("rnd_irq", 32'(irq), 32'(|(m_new & m_mask)));
            check("rnd_enable_out", 32'(ctrl_enable), 32'(m_enable));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
